// File: rtl/tpu_seq_datapath_pkg.sv
// Shared types and constants for the 2x2 TPU sequencing/edge-datapath block.
// Holds the opcode encoding, the decoded-strobe bundle and the
// saturating valid-index helper.
package tpu_pkg;

    localparam int DATA_W         = 16;
    localparam int ACC_W          = 32;
    localparam int ADDR_W         = 13;
    localparam int INSTR_W        = 16;
    localparam int OPC_MSB        = 15;
    localparam int OPC_LSB        = 13;
    localparam int IMM_W          = 13;
    localparam int ACC1_START_DEF = 3;
    localparam int ACC2_START_DEF = 4;

    // The valid index only has to reach the last capture slot, so it saturates at 7.
    localparam int              K_W   = 3;
    localparam logic [K_W-1:0] K_MAX = 3'd7;

    typedef enum logic [2:0] {
        OP_NOP         = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUT  = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_STORE       = 3'b101
    } opcode_t;

    typedef struct packed {
        logic load_weight;
        logic load_input;
        logic valid;
        logic store;
    } strobes_t;

    // Maps a raw opcode field onto the strobe levels; 110/111 decode as NOP.
    function automatic strobes_t decode_op(input logic [2:0] opc);
        strobes_t s;
        s = '0;
        case (opc)
            OP_LOAD_WEIGHT: s.load_weight = 1'b1;
            OP_LOAD_INPUT:  s.load_input  = 1'b1;
            OP_COMPUTE:     s.valid       = 1'b1;
            OP_STORE:       s.store       = 1'b1;
            default:        s = '0;
        endcase
        return s;
    endfunction

    // Next valid index: restarts at 0 whenever compute is inactive, saturates at K_MAX.
    function automatic logic [K_W-1:0] k_next(input logic valid, input logic [K_W-1:0] k);
        if (!valid) begin
            return '0;
        end
        if (k == K_MAX) begin
            return K_MAX;
        end
        return k + 1'b1;
    endfunction

endpackage

// File: rtl/tpu_seq_datapath_if.sv
// Bus between the sequencer/unified buffer/MMU side (master) and the
// sequencing datapath (slave). illegal_op exists only when
// TPU_ILLEGAL_OP_EN is defined.
interface tpu_seq_datapath_if;
    import tpu_pkg::*;

    // Inputs to the datapath
    logic [INSTR_W-1:0] instruction;
    logic [ACC_W-1:0]   a11;
    logic [ACC_W-1:0]   a12;
    logic [ACC_W-1:0]   a21;
    logic [ACC_W-1:0]   a22;
    logic [ACC_W-1:0]   acc_in1;
    logic [ACC_W-1:0]   acc_in2;

    // Outputs from the datapath
    logic [ADDR_W-1:0]  base_address;
    logic               load_weight;
    logic               load_input;
    logic               valid;
    logic               store;
    logic [DATA_W-1:0]  a_in1;
    logic [DATA_W-1:0]  a_in2;
    logic [ACC_W-1:0]   acc1_mem_0;
    logic [ACC_W-1:0]   acc1_mem_1;
    logic [ACC_W-1:0]   acc2_mem_0;
    logic [ACC_W-1:0]   acc2_mem_1;
    logic               acc1_full;
    logic               acc2_full;
`ifdef TPU_ILLEGAL_OP_EN
    logic               illegal_op;
`endif

    modport master (
        output instruction, a11, a12, a21, a22, acc_in1, acc_in2,
        input  base_address, load_weight, load_input, valid, store,
               a_in1, a_in2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1,
               acc1_full, acc2_full
`ifdef TPU_ILLEGAL_OP_EN
        , input illegal_op
`endif
    );

    modport slave (
        input  instruction, a11, a12, a21, a22, acc_in1, acc_in2,
        output base_address, load_weight, load_input, valid, store,
               a_in1, a_in2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1,
               acc1_full, acc2_full
`ifdef TPU_ILLEGAL_OP_EN
        , output illegal_op
`endif
    );

endinterface

// File: rtl/tpu_seq_datapath_acc_column.sv
// Result capture for one systolic column: two consecutive valid-cycle
// samples starting at index START, followed by a one-cycle full pulse.
module acc_column
    import tpu_pkg::*;
#(
    parameter int START = ACC1_START_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [K_W-1:0]   k,
    input  logic             valid,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] mem_0,
    output logic [ACC_W-1:0] mem_1,
    output logic             full
);

    localparam logic [K_W-1:0] SLOT_0 = K_W'(START);
    localparam logic [K_W-1:0] SLOT_1 = K_W'(START + 1);

    logic [ACC_W-1:0] mem_0_q;
    logic [ACC_W-1:0] mem_1_q;
    logic             full_q;

    // Capture the column stream in its window; full rises together with the second write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_0_q <= '0;
            mem_1_q <= '0;
            full_q  <= 1'b0;
        end else begin
            full_q <= valid && (k == SLOT_1);
            if (valid && (k == SLOT_0)) begin
                mem_0_q <= acc_in;
            end
            if (valid && (k == SLOT_1)) begin
                mem_1_q <= acc_in;
            end
        end
    end

    assign mem_0 = mem_0_q;
    assign mem_1 = mem_1_q;
    assign full  = full_q;

endmodule

// File: rtl/tpu_seq_datapath.sv
// Sequencing and edge-datapath block of the 2x2 TPU: registered
// instruction decode, diagonal activation skew into the array and
// per-column result capture. Optional feature macro: TPU_ILLEGAL_OP_EN
// adds a registered illegal_op pulse for opcodes 110/111.
module tpu_seq_datapath
    import tpu_pkg::*;
#(
    parameter int ACC1_START = ACC1_START_DEF,
    parameter int ACC2_START = ACC2_START_DEF
) (
    input  logic               clk,
    input  logic               reset,
    tpu_seq_datapath_if.slave  bus
);

    logic [2:0]        opc;
    strobes_t          strobes_d, strobes_q;
    logic [ADDR_W-1:0] base_address_d, base_address_q;
    logic [K_W-1:0]    k_q;
    logic [DATA_W-1:0] a_in1_d, a_in1_q;
    logic [DATA_W-1:0] a_in2_d, a_in2_q;
`ifdef TPU_ILLEGAL_OP_EN
    logic              illegal_d, illegal_q;
`endif

    // Only the low DATA_W bits of each activation feed the array.
    logic unused_a_hi;
    assign unused_a_hi = ^{bus.a11[ACC_W-1:DATA_W], bus.a12[ACC_W-1:DATA_W],
                           bus.a21[ACC_W-1:DATA_W], bus.a22[ACC_W-1:DATA_W]};

    // Next-state for decode and skew; the skew follows the current valid index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        a_in1_d        = '0;
        a_in2_d        = '0;
        opc            = bus.instruction[OPC_MSB:OPC_LSB];
        strobes_d      = decode_op(opc);
        base_address_d = base_address_q;
        if (opc == OP_LOAD_ADDR) begin
            base_address_d = bus.instruction[IMM_W-1:0];
        end
        if (strobes_q.valid) begin
            case (k_q)
                K_W'(0): begin
                    a_in1_d = bus.a11[DATA_W-1:0];
                end
                K_W'(1): begin
                    a_in1_d = bus.a12[DATA_W-1:0];
                    a_in2_d = bus.a21[DATA_W-1:0];
                end
                K_W'(2): begin
                    a_in2_d = bus.a22[DATA_W-1:0];
                end
                default: begin
                    a_in1_d = '0;
                    a_in2_d = '0;
                end
            endcase
        end
`ifdef TPU_ILLEGAL_OP_EN
        illegal_d = opc[2] & opc[1];
`endif
    end

    // Decode, valid index and skew registers; all clear on reset, even mid-compute.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            strobes_q      <= '0;
            base_address_q <= '0;
            k_q            <= '0;
            a_in1_q        <= '0;
            a_in2_q        <= '0;
`ifdef TPU_ILLEGAL_OP_EN
            illegal_q      <= 1'b0;
`endif
        end else begin
            strobes_q      <= strobes_d;
            base_address_q <= base_address_d;
            k_q            <= k_next(strobes_q.valid, k_q);
            a_in1_q        <= a_in1_d;
            a_in2_q        <= a_in2_d;
`ifdef TPU_ILLEGAL_OP_EN
            illegal_q      <= illegal_d;
`endif
        end
    end

    acc_column #(.START(ACC1_START)) u_col1 (
        .clk    (clk),
        .reset  (reset),
        .k      (k_q),
        .valid  (strobes_q.valid),
        .acc_in (bus.acc_in1),
        .mem_0  (bus.acc1_mem_0),
        .mem_1  (bus.acc1_mem_1),
        .full   (bus.acc1_full)
    );

    acc_column #(.START(ACC2_START)) u_col2 (
        .clk    (clk),
        .reset  (reset),
        .k      (k_q),
        .valid  (strobes_q.valid),
        .acc_in (bus.acc_in2),
        .mem_0  (bus.acc2_mem_0),
        .mem_1  (bus.acc2_mem_1),
        .full   (bus.acc2_full)
    );

    assign bus.base_address = base_address_q;
    assign bus.load_weight  = strobes_q.load_weight;
    assign bus.load_input   = strobes_q.load_input;
    assign bus.valid        = strobes_q.valid;
    assign bus.store        = strobes_q.store;
    assign bus.a_in1        = a_in1_q;
    assign bus.a_in2        = a_in2_q;
`ifdef TPU_ILLEGAL_OP_EN
    assign bus.illegal_op   = illegal_q;
`endif

endmodule

// File: tb/tb_tpu_seq_datapath.sv
// Self-checking bench for tpu_seq_datapath: directed scenarios followed by
// randomized instruction/data traffic, all compared each cycle against a
// cycle-level behavioural model of the documented rules.
module tb_tpu_seq_datapath;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tpu_seq_datapath_if bus ();

    tpu_seq_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_run is the index of the current cycle within an unbroken run of valid cycles.
    logic [12:0] m_base;
    bit          m_lw, m_li, m_valid, m_store, m_ill;
    logic [15:0] m_a1, m_a2;
    logic [31:0] m_mem [2][2];
    bit          m_full [2];
    int          m_run;
    int          col_start [2] = '{3, 4};

    task automatic model_reset();
        m_base = '0; m_lw = 0; m_li = 0; m_valid = 0; m_store = 0; m_ill = 0;
        m_a1 = '0; m_a2 = '0; m_run = 0;
        for (int c = 0; c < 2; c++) begin
            m_mem[c][0] = '0; m_mem[c][1] = '0; m_full[c] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_step();
        logic [31:0] feed1 [3];
        logic [31:0] feed2 [3];
        logic [31:0] acc   [2];
        int          op;
        if (reset) begin
            model_reset();
            return;
        end
        feed1 = '{bus.a11, bus.a12, 32'd0};
        feed2 = '{32'd0, bus.a21, bus.a22};
        acc   = '{bus.acc_in1, bus.acc_in2};
        if (m_valid && m_run < 3) begin
            m_a1 = feed1[m_run][15:0];
            m_a2 = feed2[m_run][15:0];
        end else begin
            m_a1 = '0;
            m_a2 = '0;
        end
        for (int c = 0; c < 2; c++) begin
            m_full[c] = m_valid && (m_run == col_start[c] + 1);
            if (m_valid && m_run == col_start[c])     m_mem[c][0] = acc[c];
            if (m_valid && m_run == col_start[c] + 1) m_mem[c][1] = acc[c];
        end
        m_run = m_valid ? ((m_run < 7) ? m_run + 1 : 7) : 0;
        op = int'(bus.instruction[15:13]);
        if (op == 1) m_base = bus.instruction[12:0];
        m_lw    = (op == 2);
        m_li    = (op == 3);
        m_valid = (op == 4);
        m_store = (op == 5);
        m_ill   = (op >= 6);
    endtask

    task automatic compare_all();
        check("base_address", 64'(bus.base_address), 64'(m_base));
        check("load_weight",  64'(bus.load_weight),  64'(m_lw));
        check("load_input",   64'(bus.load_input),   64'(m_li));
        check("valid",        64'(bus.valid),        64'(m_valid));
        check("store",        64'(bus.store),        64'(m_store));
        check("a_in1",        64'(bus.a_in1),        64'(m_a1));
        check("a_in2",        64'(bus.a_in2),        64'(m_a2));
        check("acc1_mem_0",   64'(bus.acc1_mem_0),   64'(m_mem[0][0]));
        check("acc1_mem_1",   64'(bus.acc1_mem_1),   64'(m_mem[0][1]));
        check("acc2_mem_0",   64'(bus.acc2_mem_0),   64'(m_mem[1][0]));
        check("acc2_mem_1",   64'(bus.acc2_mem_1),   64'(m_mem[1][1]));
        check("acc1_full",    64'(bus.acc1_full),    64'(m_full[0]));
        check("acc2_full",    64'(bus.acc2_full),    64'(m_full[1]));
`ifdef TPU_ILLEGAL_OP_EN
        check("illegal_op",   64'(bus.illegal_op),   64'(m_ill));
`endif
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_acc(input logic [31:0] v1, input logic [31:0] v2);
        bus.acc_in1 = v1;
        bus.acc_in2 = v2;
    endtask

    localparam logic [15:0] I_NOP     = 16'h0000;
    localparam logic [15:0] I_COMPUTE = 16'h8000;

    logic [15:0] exp_a1 [4] = '{16'd1, 16'd2, 16'd0, 16'd0};
    logic [15:0] exp_a2 [4] = '{16'd0, 16'd3, 16'd4, 16'd0};

    initial begin
        model_reset();
        reset = 1'b1;
        bus.instruction = 16'h2000;
        bus.a11 = '0; bus.a12 = '0; bus.a21 = '0; bus.a22 = '0;
        set_acc('0, '0);

        // Reset held two cycles with LOAD_ADDR 0 on the bus, then one cycle after.
        cycle();
        cycle();
        check("rst_valid", 64'(bus.valid), 64'd0);
        reset = 1'b0;
        cycle();
        check("post_rst_base", 64'(bus.base_address), 64'd0);

        // Decode: LOAD_ADDR 0x000F then LOAD_WEIGHT for one cycle.
        bus.instruction = 16'b001_0000000001111;
        cycle();
        check("dec_base", 64'(bus.base_address), 64'h000F);
        bus.instruction = 16'h4000;
        cycle();
        check("dec_lw_on", 64'(bus.load_weight), 64'd1);
        bus.instruction = I_NOP;
        cycle();
        check("dec_lw_off", 64'(bus.load_weight), 64'd0);
        check("dec_base_hold", 64'(bus.base_address), 64'h000F);

        // Skew and capture: valid for k = 0..7.
        bus.a11 = 32'd1; bus.a12 = 32'd2; bus.a21 = 32'd3; bus.a22 = 32'd4;
        bus.instruction = I_COMPUTE;
        cycle();
        check("cmp_valid_k0", 64'(bus.valid), 64'd1);
        for (int k = 0; k < 8; k++) begin
            set_acc((k == 3) ? 32'd10 : (k == 4) ? 32'd20 : 32'd99,
                    (k == 4) ? 32'd30 : (k == 5) ? 32'd40 : 32'd77);
            bus.instruction = (k < 7) ? I_COMPUTE : I_NOP;
            cycle();
            if (k <= 3) begin
                check("skew_a_in1", 64'(bus.a_in1), 64'(exp_a1[k]));
                check("skew_a_in2", 64'(bus.a_in2), 64'(exp_a2[k]));
            end
            check("cap_acc1_full", 64'(bus.acc1_full), 64'(k + 1 == 5));
            check("cap_acc2_full", 64'(bus.acc2_full), 64'(k + 1 == 6));
        end
        check("cap_acc1_mem_0", 64'(bus.acc1_mem_0), 64'd10);
        check("cap_acc1_mem_1", 64'(bus.acc1_mem_1), 64'd20);
        check("cap_acc2_mem_0", 64'(bus.acc2_mem_0), 64'd30);
        check("cap_acc2_mem_1", 64'(bus.acc2_mem_1), 64'd40);

        // Early end: COMPUTE for 4 cycles writes only acc1_mem_0, no full pulses.
        bus.instruction = I_NOP;
        cycle();
        cycle();
        bus.instruction = I_COMPUTE;
        cycle();
        for (int k = 0; k < 4; k++) begin
            set_acc(32'd55, 32'd66);
            bus.instruction = (k < 3) ? I_COMPUTE : I_NOP;
            cycle();
            check("early_acc1_full", 64'(bus.acc1_full), 64'd0);
            check("early_acc2_full", 64'(bus.acc2_full), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("early_full_after", 64'({bus.acc1_full, bus.acc2_full}), 64'd0);
        end
        check("early_acc1_mem_0", 64'(bus.acc1_mem_0), 64'd55);
        check("early_acc1_mem_1", 64'(bus.acc1_mem_1), 64'd20);
        check("early_acc2_mem_0", 64'(bus.acc2_mem_0), 64'd30);
        check("early_acc2_mem_1", 64'(bus.acc2_mem_1), 64'd40);

        // Reset asserted during k = 2 clears everything the next cycle.
        bus.instruction = I_COMPUTE;
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("midrst_valid", 64'(bus.valid), 64'd0);
        check("midrst_a_in", 64'({bus.a_in1, bus.a_in2}), 64'd0);
        check("midrst_mems", 64'({bus.acc1_mem_0 | bus.acc1_mem_1 | bus.acc2_mem_0 | bus.acc2_mem_1}), 64'd0);
        reset = 1'b0;
        bus.instruction = I_NOP;
        cycle();

`ifdef TPU_ILLEGAL_OP_EN
        // Opcodes 110/111 pulse illegal_op and leave the strobes low.
        bus.instruction = 16'hC000;
        cycle();
        check("ill_pulse", 64'(bus.illegal_op), 64'd1);
        check("ill_strobes", 64'({bus.load_weight, bus.load_input, bus.valid, bus.store}), 64'd0);
        bus.instruction = I_NOP;
        cycle();
        check("ill_clear", 64'(bus.illegal_op), 64'd0);
`endif

        // Random traffic with long COMPUTE runs and occasional resets.
        begin
            int hold;
            hold = 0;
            for (int i = 0; i < 600; i++) begin
                logic [2:0] op;
                if (hold > 0) begin
                    op = 3'd4;
                    hold--;
                end else if ($urandom_range(0, 3) == 0) begin
                    op = 3'd4;
                    hold = $urandom_range(0, 9);
                end else begin
                    op = 3'($urandom_range(0, 7));
                end
                bus.instruction = {op, 13'($urandom)};
                bus.a11 = $urandom; bus.a12 = $urandom;
                bus.a21 = $urandom; bus.a22 = $urandom;
                set_acc($urandom, $urandom);
                reset = ($urandom_range(0, 59) == 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
